// File: rtl/i2c_pkg.sv
// Shared I2C target definitions: field widths, R/W bit position and FSM states.
// Pure declarations; no logic, no latency.
package i2c_pkg;
  localparam int I2C_ADDR_W = 7;
  localparam int I2C_BYTE_W = 8;
  localparam int I2C_RW_BIT = 0;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_BYTE,
    WR_ACK,
    RD_BYTE,
    RD_ACK,
    WAIT_STOP
  } i2c_state_t;
endpackage

// File: rtl/i2c_slave_target_if.sv
// Local-side and SCL signals of the I2C target; sda stays a plain inout on the module.
// Pulses (rx_valid, tx_req) are single-cycle; there is no backpressure.
interface i2c_slave_target_if;
  import i2c_pkg::*;

  logic                  scl;
  logic [I2C_BYTE_W-1:0] rx_data;
  logic                  rx_valid;
  logic [I2C_BYTE_W-1:0] tx_data;
  logic                  tx_req;
  logic                  addr_hit;
  logic                  busy;

  modport slave (
    input  scl,
    input  tx_data,
    output rx_data,
    output rx_valid,
    output tx_req,
    output addr_hit,
    output busy
  );

  modport master (
    output scl,
    output tx_data,
    input  rx_data,
    input  rx_valid,
    input  tx_req,
    input  addr_hit,
    input  busy
  );
endinterface

// File: rtl/i2c_bus_sync.sv
// Synchronises SCL/SDA and flags SCL edges plus START/STOP; events appear SYNC_STAGES+1
// cycles after the pin edge. No backpressure: every output is a one-cycle strobe.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk100mhz,
  input  logic res,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);
  logic [SYNC_STAGES-1:0] scl_sr;
  logic [SYNC_STAGES-1:0] sda_sr;
  logic                   scl_d;
  logic                   sda_d;
  logic                   scl_s;

  // Reset to the idle bus level so leaving reset never fakes an edge.
  always_ff @(posedge clk100mhz or posedge res) begin
    if (res) begin
      scl_sr <= '1;
      sda_sr <= '1;
      scl_d  <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_sr <= {scl_sr[SYNC_STAGES-2:0], scl};
      sda_sr <= {sda_sr[SYNC_STAGES-2:0], sda};
      scl_d  <= scl_sr[SYNC_STAGES-1];
      sda_d  <= sda_sr[SYNC_STAGES-1];
    end
  end

  assign scl_s     = scl_sr[SYNC_STAGES-1];
  assign sda_s     = sda_sr[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
endmodule

// File: rtl/i2c_slave_target.sv
// Oversampled I2C target: decodes address/write bytes, ACKs, and serves read bytes from tx_data.
// Strobes fire a few clk100mhz cycles after the SCL edge; local side cannot stall the bus.
module i2c_slave_target
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR  = 7'h2A,
  parameter int                    SYNC_STAGES = 2
) (
  input  logic                clk100mhz,
  input  logic                res,
  inout  wire                 sda,
  i2c_slave_target_if.slave   bus
);
  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk100mhz (clk100mhz),
    .res       (res),
    .scl       (bus.scl),
    .sda       (sda),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  i2c_state_t            state, state_n;
  logic [3:0]            bit_cnt, bit_cnt_n;
  logic [I2C_BYTE_W-1:0] shreg, shreg_n, shift_in;
  logic [I2C_BYTE_W-1:0] rx_data_q, rx_data_n;
  logic                  sda_oe, sda_oe_n;
  logic                  ack_ph, ack_ph_n;
  logic                  addr_hit_q, addr_hit_n;
  logic                  busy_q, busy_n;
  logic                  rx_valid_q, rx_valid_n;
  logic                  tx_req_c;

  assign shift_in = {shreg[I2C_BYTE_W-2:0], sda_s};

  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    shreg_n    = shreg;
    sda_oe_n   = sda_oe;
    ack_ph_n   = ack_ph;
    addr_hit_n = addr_hit_q;
    busy_n     = busy_q;
    rx_data_n  = rx_data_q;
    rx_valid_n = 1'b0;
    tx_req_c   = 1'b0;

    if (stop_det) begin
      state_n    = IDLE;
      bit_cnt_n  = '0;
      sda_oe_n   = 1'b0;
      ack_ph_n   = 1'b0;
      addr_hit_n = 1'b0;
      busy_n     = 1'b0;
    end else if (start_det) begin
      state_n    = ADDR;
      bit_cnt_n  = '0;
      sda_oe_n   = 1'b0;
      ack_ph_n   = 1'b0;
      addr_hit_n = 1'b0;
      busy_n     = 1'b1;
    end else begin
      case (state)
        IDLE: ;
        ADDR: if (scl_rise) begin
          shreg_n   = shift_in;
          bit_cnt_n = bit_cnt + 4'd1;
          if (bit_cnt == 4'd7)
            state_n = (shift_in[I2C_BYTE_W-1:1] == SLAVE_ADDR) ? ADDR_ACK : WAIT_STOP;
        end
        // ack_ph marks the low-high-low window during which sda is held low.
        ADDR_ACK, WR_ACK: if (scl_fall) begin
          if (!ack_ph) begin
            sda_oe_n = 1'b1;
            ack_ph_n = 1'b1;
            if (state == ADDR_ACK) addr_hit_n = 1'b1;
          end else begin
            ack_ph_n  = 1'b0;
            bit_cnt_n = '0;
            if (state == ADDR_ACK && shreg[I2C_RW_BIT]) begin
              tx_req_c = 1'b1;
              shreg_n  = bus.tx_data;
              sda_oe_n = ~bus.tx_data[I2C_BYTE_W-1];
              state_n  = RD_BYTE;
            end else begin
              sda_oe_n = 1'b0;
              state_n  = WR_BYTE;
            end
          end
        end
        WR_BYTE: if (scl_rise) begin
          shreg_n   = shift_in;
          bit_cnt_n = bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
            rx_data_n  = shift_in;
            rx_valid_n = 1'b1;
            state_n    = WR_ACK;
          end
        end
        // MSB went out when the byte was loaded; the remaining falls shift the rest.
        RD_BYTE: if (scl_fall) begin
          if (bit_cnt == 4'd7) begin
            sda_oe_n  = 1'b0;
            bit_cnt_n = '0;
            ack_ph_n  = 1'b0;
            state_n   = RD_ACK;
          end else begin
            shreg_n   = {shreg[I2C_BYTE_W-2:0], 1'b0};
            sda_oe_n  = ~shreg[I2C_BYTE_W-2];
            bit_cnt_n = bit_cnt + 4'd1;
          end
        end
        RD_ACK: if (scl_rise) begin
          if (sda_s) state_n  = WAIT_STOP;
          else       ack_ph_n = 1'b1;
        end else if (scl_fall && ack_ph) begin
          tx_req_c  = 1'b1;
          shreg_n   = bus.tx_data;
          sda_oe_n  = ~bus.tx_data[I2C_BYTE_W-1];
          bit_cnt_n = '0;
          ack_ph_n  = 1'b0;
          state_n   = RD_BYTE;
        end
        WAIT_STOP: sda_oe_n = 1'b0;
        default:   state_n  = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk100mhz or posedge res) begin
    if (res) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      sda_oe     <= 1'b0;
      ack_ph     <= 1'b0;
      addr_hit_q <= 1'b0;
      busy_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      shreg      <= shreg_n;
      sda_oe     <= sda_oe_n;
      ack_ph     <= ack_ph_n;
      addr_hit_q <= addr_hit_n;
      busy_q     <= busy_n;
      rx_data_q  <= rx_data_n;
      rx_valid_q <= rx_valid_n;
    end
  end

  assign sda          = sda_oe ? 1'b0 : 1'bz;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.tx_req   = tx_req_c;
  assign bus.addr_hit = addr_hit_q;
  assign bus.busy     = busy_q;
endmodule

// File: tb/tb_i2c_slave_target.sv
// Directed I2C master stimulus with a queue scoreboard for rx_valid / tx_req strobes.
module tb_i2c_slave_target;
  import i2c_pkg::*;

  localparam int Q = 20;  // quarter SCL period in clk100mhz cycles

  logic clk100mhz = 1'b0;
  logic res;
  logic m_low;
  wire  sda;

  i2c_slave_target_if bus();

  assign sda = m_low ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_slave_target #(.SLAVE_ADDR(7'h2A), .SYNC_STAGES(2)) dut (
    .clk100mhz (clk100mhz),
    .res       (res),
    .sda       (sda),
    .bus       (bus.slave)
  );

  always #5 clk100mhz = ~clk100mhz;

  int checks    = 0;
  int errors    = 0;
  int rx_pulses = 0;
  int tx_pulses = 0;
  logic [7:0] exp_rx[$];
  logic [7:0] exp_tx[$];
  logic dut_low_seen = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitors: pop the expected byte whenever the DUT strobes.
  always @(negedge clk100mhz) begin
    if (bus.rx_valid) begin
      rx_pulses++;
      if (exp_rx.size() == 0) begin
        checks++; errors++;
        $display("FAIL rx_unexpected: rx_valid with data %0h, none expected", bus.rx_data);
      end else begin
        chk("rx_data", 32'(bus.rx_data), 32'(exp_rx.pop_front()));
      end
    end
    if (bus.tx_req) begin
      tx_pulses++;
      if (exp_tx.size() == 0) begin
        checks++; errors++;
        $display("FAIL tx_unexpected: tx_req with tx_data %0h, none expected", bus.tx_data);
      end else begin
        chk("tx_latch", 32'(bus.tx_data), 32'(exp_tx.pop_front()));
      end
    end
    if (bus.rx_valid || bus.tx_req)
      chk("rx_tx_exclusive", 32'(bus.rx_valid & bus.tx_req), 32'd0);
    if (sda === 1'b0 && !m_low) dut_low_seen = 1'b1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk100mhz);
  endtask

  task automatic bus_start();
    m_low = 1'b0; tick(Q);
    bus.scl = 1'b1; tick(Q);
    m_low = 1'b1; tick(Q);
    bus.scl = 1'b0; tick(Q);
  endtask

  task automatic bus_stop();
    m_low = 1'b1; tick(Q);
    bus.scl = 1'b1; tick(Q);
    m_low = 1'b0; tick(Q);
  endtask

  task automatic write_bit(input logic b);
    m_low = ~b; tick(Q);
    bus.scl = 1'b1; tick(2*Q);
    bus.scl = 1'b0; tick(Q);
  endtask

  task automatic read_bit(output logic b);
    m_low = 1'b0; tick(Q);
    bus.scl = 1'b1; tick(Q);
    b = sda; tick(Q);
    bus.scl = 1'b0; tick(Q);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic recv_byte(output logic [7:0] d, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(nack);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ack;
    logic [7:0] d;
    logic [7:0] abyte;

    res = 1'b1; m_low = 1'b0; bus.scl = 1'b1; bus.tx_data = 8'h00;
    tick(3);
    chk("rst_sda",      32'(sda),          32'd1);
    chk("rst_rx_data",  32'(bus.rx_data),  32'h00);
    chk("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    chk("rst_tx_req",   32'(bus.tx_req),   32'd0);
    chk("rst_addr_hit", 32'(bus.addr_hit), 32'd0);
    chk("rst_busy",     32'(bus.busy),     32'd0);
    chk("rst_state",    32'(dut.state),    32'(IDLE));
    res = 1'b0; tick(5);

    // Write 0xA5 to 0x2A
    exp_rx.push_back(8'hA5);
    bus_start();
    chk("wr_busy_start", 32'(bus.busy), 32'd1);
    send_byte(8'h54, ack);
    chk("wr_addr_ack", 32'(ack), 32'd0);
    chk("wr_addr_hit", 32'(bus.addr_hit), 32'd1);
    send_byte(8'hA5, ack);
    chk("wr_data_ack", 32'(ack), 32'd0);
    bus_stop();
    chk("wr_busy_stop", 32'(bus.busy), 32'd0);
    chk("wr_rx_data", 32'(bus.rx_data), 32'hA5);
    chk("wr_addr_hit_stop", 32'(bus.addr_hit), 32'd0);
    chk("wr_rx_pulses", 32'(rx_pulses), 32'd1);

    // Address mismatch
    dut_low_seen = 1'b0;
    bus_start();
    send_byte(8'h56, ack);
    chk("mm_ack", 32'(ack), 32'd1);
    chk("mm_state", 32'(dut.state), 32'(WAIT_STOP));
    chk("mm_addr_hit", 32'(bus.addr_hit), 32'd0);
    bus_stop();
    chk("mm_sda_never_low", 32'(dut_low_seen), 32'd0);
    chk("mm_state_stop", 32'(dut.state), 32'(IDLE));
    chk("mm_rx_pulses", 32'(rx_pulses), 32'd1);

    // Read 0x3C (ACK) then 0xC3 (NACK)
    bus.tx_data = 8'h3C; exp_tx.push_back(8'h3C);
    bus_start();
    send_byte(8'h55, ack);
    chk("rd_addr_ack", 32'(ack), 32'd0);
    bus.tx_data = 8'hC3; exp_tx.push_back(8'hC3);
    recv_byte(d, 1'b0);
    chk("rd_byte0", 32'(d), 32'h3C);
    recv_byte(d, 1'b1);
    chk("rd_byte1", 32'(d), 32'hC3);
    chk("rd_sda_released", 32'(sda), 32'd1);
    chk("rd_state_nack", 32'(dut.state), 32'(WAIT_STOP));
    bus_stop();
    chk("rd_tx_pulses", 32'(tx_pulses), 32'd2);
    chk("rd_busy_stop", 32'(bus.busy), 32'd0);

    // Write 0x11, repeated START, read 0x7E
    exp_rx.push_back(8'h11);
    bus_start();
    send_byte(8'h54, ack);
    chk("rs_wr_addr_ack", 32'(ack), 32'd0);
    send_byte(8'h11, ack);
    chk("rs_wr_data_ack", 32'(ack), 32'd0);
    chk("rs_addr_hit_wr", 32'(bus.addr_hit), 32'd1);
    bus.tx_data = 8'h7E; exp_tx.push_back(8'h7E);
    bus_start();
    chk("rs_addr_hit_addrphase", 32'(bus.addr_hit), 32'd0);
    chk("rs_busy", 32'(bus.busy), 32'd1);
    send_byte(8'h55, ack);
    chk("rs_rd_addr_ack", 32'(ack), 32'd0);
    chk("rs_addr_hit_rd", 32'(bus.addr_hit), 32'd1);
    recv_byte(d, 1'b1);
    chk("rs_rd_byte", 32'(d), 32'h7E);
    chk("rs_rx_data_kept", 32'(bus.rx_data), 32'h11);
    bus_stop();
    chk("rs_addr_hit_stop", 32'(bus.addr_hit), 32'd0);

    // Abort after 4 data bits
    bus_start();
    send_byte(8'h54, ack);
    chk("ab_addr_ack", 32'(ack), 32'd0);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
    bus_stop();
    chk("ab_rx_pulses", 32'(rx_pulses), 32'd2);
    chk("ab_state", 32'(dut.state), 32'(IDLE));
    chk("ab_sda", 32'(sda), 32'd1);
    chk("ab_busy", 32'(bus.busy), 32'd0);

    // Reset while the target holds the address ACK low
    bus_start();
    abyte = 8'h54;
    for (int i = 7; i >= 0; i--) write_bit(abyte[i]);
    m_low = 1'b0; tick(2);
    chk("rst_ack_driven", 32'(sda), 32'd0);
    res = 1'b1; #1;
    chk("rst_mid_sda", 32'(sda), 32'd1);
    chk("rst_mid_busy", 32'(bus.busy), 32'd0);
    chk("rst_mid_addr_hit", 32'(bus.addr_hit), 32'd0);
    chk("rst_mid_rx_data", 32'(bus.rx_data), 32'h00);
    chk("rst_mid_state", 32'(dut.state), 32'(IDLE));
    tick(2); res = 1'b0; tick(2);
    bus.scl = 1'b1; tick(Q);
    exp_rx.push_back(8'h5A);
    bus_start();
    send_byte(8'h54, ack);
    chk("post_rst_addr_ack", 32'(ack), 32'd0);
    send_byte(8'h5A, ack);
    chk("post_rst_data_ack", 32'(ack), 32'd0);
    bus_stop();
    chk("post_rst_rx_data", 32'(bus.rx_data), 32'h5A);
    chk("post_rst_busy", 32'(bus.busy), 32'd0);

    tick(10);
    chk("total_rx_pulses", 32'(rx_pulses), 32'd3);
    chk("total_tx_pulses", 32'(tx_pulses), 32'd3);
    chk("exp_rx_drained", 32'(exp_rx.size()), 32'd0);
    chk("exp_tx_drained", 32'(exp_tx.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/i2c_slave_target.md
Name: i2c_slave_target

Overview:
- Fabric-side I2C target that sits directly downstream of the I2C master on the shared SCL/SDA bus.
- Consumes the address byte and data bytes the master drives, and returns ACK, or read data on read transactions.
- Presents received write bytes to local logic as a one-cycle valid strobe.
- Fetches read bytes from local logic through a request strobe.
- All bus sampling is oversampled on the system 100 MHz clock; the block never uses SCL as a clock.

Parameters:
- SLAVE_ADDR, 7'h2A, 7-bit target address compared against address byte bits [7:1].
- SYNC_STAGES, 2, flip-flop synchroniser depth on the SCL and SDA inputs (minimum 2).

Ports:
- clk100mhz  input  1  system clock; all logic on its rising edge.
- res  input  1  asynchronous, active-high reset.
- scl  input  1  bus clock from the master; this block only samples it.
- sda  inout  1  open-drain bus data; the block drives 0 or Z, never 1.
- rx_data  output  8  last byte written by the master.
- rx_valid  output  1  one-cycle pulse; rx_data is new.
- tx_data  input  8  byte to return on a read; sampled when tx_req pulses.
- tx_req  output  1  one-cycle pulse; tx_data is latched this cycle.
- addr_hit  output  1  high from the address ACK until STOP or repeated START.
- busy  output  1  high from START until STOP.

Behaviour:
- Reset:
  - state=IDLE, sda released (Z), rx_data=0, rx_valid=0, tx_req=0, addr_hit=0, busy=0.
  - Reset asserted mid-transfer releases sda immediately (asynchronous).
- Input synchronisation and edge detection:
  - scl and sda each pass through SYNC_STAGES flops.
  - Edge detect compares the synchronised value with a one-flop delayed copy.
  - Detection latency is SYNC_STAGES+1 clk100mhz cycles from the pin edge.
- Bus conditions:
  - START: synced sda falls while synced scl is high.
  - STOP: synced sda rises while synced scl is high.
  - Both have priority over every state transition.
- Sampling and driving rules:
  - Data bits are sampled on the detected scl rising edge, MSB first.
  - Outgoing sda changes only on the cycle after a detected scl falling edge.
- States: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP.
- IDLE: on START, clear bit counter to 0, busy=1, go to ADDR.
- ADDR:
  - Shift 8 bits.
  - After bit 8, if byte[7:1]==SLAVE_ADDR, go to ADDR_ACK; otherwise go to WAIT_STOP with sda released.
- ADDR_ACK:
  - At the next scl fall, drive sda=0 and set addr_hit=1.
  - At the following scl fall, leave ACK.
  - If R/W=0: release sda and go to WR_BYTE.
  - If R/W=1: pulse tx_req, load the shift register from tx_data, drive its MSB, go to RD_BYTE.
- WR_BYTE:
  - Shift 8 bits.
  - The cycle after the 8th sampled bit, update rx_data and pulse rx_valid; go to WR_ACK.
- WR_ACK: ACK exactly as in ADDR_ACK (sda low for one scl low-high-low window), then return to WR_BYTE.
- RD_BYTE:
  - At each scl fall, present the next bit; a 0 bit drives sda low, a 1 bit releases sda.
  - After the 8th scl fall, release sda and go to RD_ACK.
- RD_ACK: sample sda on scl rise.
  - 0 = master ACK: at the next scl fall, pulse tx_req, reload from tx_data, go to RD_BYTE.
  - 1 = master NACK: go to WAIT_STOP.
- WAIT_STOP: sda released; ignore bits until STOP or START.
- STOP in any state: release sda, addr_hit=0, busy=0, go to IDLE. A partial byte is discarded with no rx_valid.
- Repeated START in any non-IDLE state: release sda, addr_hit=0, clear bit counter, go to ADDR.
- If START and a scl edge are detected on the same cycle, START wins.
- rx_valid and tx_req never assert on the same cycle.
- The bit counter is 4 bits, counting 0..8; it never wraps within a byte.

Decomposition:
- Shared package i2c_pkg:
  - state enum constants;
  - I2C_ADDR_W=7, I2C_BYTE_W=8;
  - the R/W bit index constant (0).
- Sub-module i2c_bus_sync:
  - synchroniser plus edge detection;
  - outputs scl_rise, scl_fall, start_det, stop_det, sda_s.

Test Plan:
- Write: START, address byte 0x54 (7'h2A, W), data 0xA5, STOP -> sda low during both 9th clocks; rx_data=0xA5; exactly one rx_valid pulse; busy 1 then 0.
- Address mismatch: address byte 0x56 -> sda never driven low; no rx_valid; state WAIT_STOP until STOP, then IDLE.
- Read: address byte 0x55 with tx_data=0x3C, master ACK, then tx_data=0xC3, master NACK, STOP -> bus carries 0x3C then 0xC3; two tx_req pulses; sda released after NACK.
- Repeated START: write 0x11 to 0x54, repeated START, address 0x55, read 0x7E -> rx_data=0x11, then read 0x7E; addr_hit stays 1 across the repeated START except during the address phase.
- Abort: STOP after 4 data bits of a write -> no rx_valid; IDLE; sda Z.
- Reset: assert res while sda is driven low during ACK -> sda Z in the same cycle; all outputs at reset values; the next transaction completes normally.
